// File: rtl/sdf_pkg.sv
// Shared arithmetic helpers for the radix-2 SDF pipeline stages: width math,
// rounding shifts and saturation on a wide signed working type.
package sdf_pkg;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int data_width(input int integer_size, input int fract_size);
    return integer_size + fract_size;
  endfunction

  // Left shift that maps a stage-local index k onto the shared NFFT twiddle ROM.
  function automatic int tw_shift(input int nfft, input int stage_no);
    return clog2(nfft) - stage_no;
  endfunction

  function automatic calc_t sat_to_width(input calc_t x, input int width);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic sat_hit(input calc_t x, input int width);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    return (x > hi) || (x < lo);
  endfunction

  // Round half up, then arithmetic shift right.
  function automatic calc_t round_shift(input calc_t x, input int sh);
    if (sh <= 0) return x;
    return (x + (calc_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

endpackage

// File: rtl/sdf_r2_stage_p_if.sv
// Streaming sample, twiddle-ROM and overflow signals of one SDF stage.
interface sdf_r2_stage_p_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 5
);
  logic                         in_valid;
  logic                         inverse;
  logic signed [DATA_WIDTH-1:0] in_r;
  logic signed [DATA_WIDTH-1:0] in_i;
  logic signed [DATA_WIDTH-1:0] tw_r;
  logic signed [DATA_WIDTH-1:0] tw_i;
  logic [ADDR_WIDTH-1:0]        tw_addr;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_r;
  logic signed [DATA_WIDTH-1:0] out_i;
  logic                         ovf_clr;
  logic                         ovf;

  modport master (
    output in_valid, inverse, in_r, in_i, tw_r, tw_i, ovf_clr,
    input  tw_addr, out_valid, out_r, out_i, ovf
  );

  modport slave (
    input  in_valid, inverse, in_r, in_i, tw_r, tw_i, ovf_clr,
    output tw_addr, out_valid, out_r, out_i, ovf
  );
endinterface

// File: rtl/sdf_cmul_rnd.sv
// Combinational complex multiply a * w (or a * conj(w)) with round-to-nearest
// back to the sample format and saturation; sat flags any clipping.
module sdf_cmul_rnd
  import sdf_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int FRACT_SIZE = 12
) (
  input  logic signed [DATA_WIDTH-1:0] a_r,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] w_r,
  input  logic signed [DATA_WIDTH-1:0] w_i,
  input  logic                         conj,
  output logic signed [DATA_WIDTH-1:0] p_r,
  output logic signed [DATA_WIDTH-1:0] p_i,
  output logic                         sat
);

  calc_t wi_neg;
  calc_t wi_eff;
  calc_t acc_r;
  calc_t acc_i;

  always_comb begin
    // Negating the most-negative twiddle must clip rather than wrap.
    wi_neg = -calc_t'(w_i);
    wi_eff = conj ? sat_to_width(wi_neg, DATA_WIDTH) : calc_t'(w_i);
    acc_r  = round_shift(calc_t'(a_r) * calc_t'(w_r) - calc_t'(a_i) * wi_eff, FRACT_SIZE);
    acc_i  = round_shift(calc_t'(a_r) * wi_eff + calc_t'(a_i) * calc_t'(w_r), FRACT_SIZE);
    p_r    = DATA_WIDTH'(sat_to_width(acc_r, DATA_WIDTH));
    p_i    = DATA_WIDTH'(sat_to_width(acc_i, DATA_WIDTH));
    sat    = sat_hit(acc_r, DATA_WIDTH) | sat_hit(acc_i, DATA_WIDTH)
           | (conj & sat_hit(wi_neg, DATA_WIDTH));
  end

endmodule

// File: rtl/sdf_r2_stage_p.sv
// Radix-2 single-path delay-feedback stage: fill half loads the delay line and
// emits the rotated previous differences, butterfly half emits sums.
module sdf_r2_stage_p
  import sdf_pkg::*;
#(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int NFFT         = 64,
  parameter int STAGE_NO     = 1,
  parameter int TWIDDLE_EN   = 1,
  parameter int SCALE_EN     = 0
) (
  input logic             clk,
  input logic             rst,
  sdf_r2_stage_p_if.slave bus
);

  localparam int DATA_WIDTH = data_width(INTEGER_SIZE, FRACT_SIZE);
  localparam int SUM_W      = DATA_WIDTH + 1;
  localparam int LOG_N      = clog2(NFFT);
  localparam int ADDR_W     = LOG_N - 1;
  localparam int D          = 2 ** (STAGE_NO - 1);
  localparam int TW_SH      = tw_shift(NFFT, STAGE_NO);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]      wide_t;

  logic [STAGE_NO-1:0] pos;
  logic [LOG_N-1:0]    fpos;
  logic                half;
  logic                primed;
  logic                inverse_q;
  logic [31:0]         k_full;

  sample_t dl_r [D];
  sample_t dl_i [D];
  sample_t f_r, f_i;
  sample_t rot_r, rot_i;
  logic    rot_sat;
  wide_t   sum_r, sum_i, dif_r, dif_i;
  sample_t dl_in_r, dl_in_i;
  sample_t nxt_r, nxt_i;
  logic    sat_evt;

  function automatic calc_t scaled(input wide_t x);
    return (SCALE_EN != 0) ? round_shift(calc_t'(x), 1) : calc_t'(x);
  endfunction

  function automatic sample_t fin(input wide_t x);
    return DATA_WIDTH'(sat_to_width(scaled(x), DATA_WIDTH));
  endfunction

  function automatic logic fin_sat(input wide_t x);
    return sat_hit(scaled(x), DATA_WIDTH);
  endfunction

  assign half        = pos[STAGE_NO-1];
  assign k_full      = 32'(pos) & 32'(D - 1);
  assign bus.tw_addr = ADDR_W'(k_full << TW_SH);

  assign f_r   = dl_r[D-1];
  assign f_i   = dl_i[D-1];
  assign sum_r = SUM_W'(f_r) + SUM_W'(bus.in_r);
  assign sum_i = SUM_W'(f_i) + SUM_W'(bus.in_i);
  assign dif_r = SUM_W'(f_r) - SUM_W'(bus.in_r);
  assign dif_i = SUM_W'(f_i) - SUM_W'(bus.in_i);

  sdf_cmul_rnd #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRACT_SIZE (FRACT_SIZE)
  ) u_cmul (
    .a_r  (f_r),
    .a_i  (f_i),
    .w_r  (bus.tw_r),
    .w_i  (bus.tw_i),
    .conj (inverse_q),
    .p_r  (rot_r),
    .p_i  (rot_i),
    .sat  (rot_sat)
  );

  always_comb begin
    // NOTE: every variable gets a default before the branch so no path infers a latch.
    dl_in_r = bus.in_r;
    dl_in_i = bus.in_i;
    nxt_r   = (TWIDDLE_EN != 0) ? rot_r : f_r;
    nxt_i   = (TWIDDLE_EN != 0) ? rot_i : f_i;
    sat_evt = (TWIDDLE_EN != 0) && rot_sat;
    if (half) begin
      dl_in_r = fin(dif_r);
      dl_in_i = fin(dif_i);
      nxt_r   = fin(sum_r);
      nxt_i   = fin(sum_i);
      sat_evt = fin_sat(sum_r) | fin_sat(sum_i) | fin_sat(dif_r) | fin_sat(dif_i);
    end
  end

  // NOTE: the delay line is cleared on reset so a restarted frame never sees stale differences.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        dl_r[i] <= '0;
        dl_i[i] <= '0;
      end
    end else if (bus.in_valid) begin
      dl_r[0] <= dl_in_r;
      dl_i[0] <= dl_in_i;
      for (int i = 1; i < D; i++) begin
        dl_r[i] <= dl_r[i-1];
        dl_i[i] <= dl_i[i-1];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos           <= '0;
      fpos          <= '0;
      primed        <= 1'b0;
      inverse_q     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_r     <= '0;
      bus.out_i     <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid & (primed | half);
      bus.ovf       <= (bus.in_valid & sat_evt) | (bus.ovf & ~bus.ovf_clr);
      if (bus.in_valid) begin
        pos       <= pos + 1'b1;
        fpos      <= fpos + 1'b1;
        bus.out_r <= nxt_r;
        bus.out_i <= nxt_i;
        if (half) primed <= 1'b1;
        if (fpos == '0) inverse_q <= bus.inverse;
      end
    end
  end

endmodule
